ifetch_stage: RTL and testbench

Instruction-fetch stage of the rv64 ready-valid pipeline, between the PC generator and the decode register (regD). It accepts PCs under a valid/allow_in handshake and issues in-order requests to the instruction memory. Returned instructions are buffered and presented to decode with their PC. On a redirect from execute it kills every in-flight and buffered fetch.

---
 rtl/rv64_pkg.sv | 11 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/ifetch_stage.sv | 95 +++++++++
 tb/tb_ifetch_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// Shared rv64 fetch-path widths and the entry handed from fetch to decode.
package rv64_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with synchronous clear; head visible combinationally, one-cycle write-to-read.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read past the valid count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC handshake to imem, in-order response buffering, flush by dropping late responses.
// Request at t, response at t+k gives fetch_o_valid at t+k+1; PC intake stalls once DEPTH credits are in use.
module ifetch_stage #(
    parameter int XLEN  = rv64_pkg::XLEN,
    parameter int ILEN  = rv64_pkg::ILEN,
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_i_valid,
    input  logic [XLEN-1:0] pc_i_pc,
    output logic            fetch_o_allow_in,
    output logic            imem_o_req_valid,
    output logic [XLEN-1:0] imem_o_req_addr,
    input  logic            imem_i_req_ready,
    input  logic            imem_i_resp_valid,
    input  logic [ILEN-1:0] imem_i_resp_data,
    input  logic            imem_i_resp_err,
    input  logic            execute_i_need_jump,
    input  logic            regD_i_allow_in,
    output logic            fetch_o_valid,
    output logic [XLEN-1:0] fetch_o_pc,
    output logic [ILEN-1:0] fetch_o_instr,
    output logic            fetch_o_fault
);
    import rv64_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);

    logic [CW-1:0]   pcq_count, rq_count, drop_cnt;
    logic            pcq_full, pcq_empty, rq_full, rq_empty;
    logic [XLEN-1:0] pcq_head;
    fetch_entry_t    rq_in, rq_head;
    logic            flush, credit_ok, req_fire, resp_keep, rq_pop;

    assign flush = execute_i_need_jump;

    // In-flight count includes responses already marked for dropping, so the PC FIFO can never overflow.
    assign credit_ok        = ((CW+1)'(pcq_count) + (CW+1)'(rq_count)) < (CW+1)'(DEPTH);
    assign imem_o_req_valid = pc_i_valid & credit_ok & ~flush & ~rst;
    assign fetch_o_allow_in = imem_i_req_ready & credit_ok & ~flush & ~rst;
    assign imem_o_req_addr  = pc_i_pc;
    assign req_fire         = imem_o_req_valid & imem_i_req_ready;

    assign resp_keep = imem_i_resp_valid & ~flush & (drop_cnt == '0);
    assign rq_pop    = fetch_o_valid & regD_i_allow_in;
    assign rq_in     = '{pc: pcq_head, instr: imem_i_resp_data, fault: imem_i_resp_err};

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_i_pc),
        .pop       (imem_i_resp_valid),
        .clear     (1'b0),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data (rq_in),
        .pop       (rq_pop),
        .clear     (flush),
        .head      (rq_head),
        .full      (rq_full),
        .empty     (rq_empty),
        .count     (rq_count)
    );

    // On flush every request still in flight after this cycle's response becomes a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= pcq_count - CW'(imem_i_resp_valid);
        end else if (imem_i_resp_valid && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    assign fetch_o_valid = ~rq_empty;
    assign fetch_o_pc    = fetch_o_valid ? rq_head.pc    : '0;
    assign fetch_o_instr = fetch_o_valid ? rq_head.instr : '0;
    assign fetch_o_fault = fetch_o_valid & rq_head.fault;

    resp_underflow: assert property (@(posedge clk) disable iff (rst) imem_i_resp_valid |-> !pcq_empty);
    pcq_no_overflow: assert property (@(posedge clk) disable iff (rst) req_fire |-> !pcq_full || imem_i_resp_valid);
    rq_no_overflow: assert property (@(posedge clk) disable iff (rst) resp_keep |-> !rq_full || rq_pop);
endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage against a queue-based model of the fetch pipeline.
module tb_ifetch_stage;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_i_valid, imem_i_req_ready, imem_i_resp_valid, imem_i_resp_err;
    logic [63:0] pc_i_pc;
    logic [31:0] imem_i_resp_data;
    logic        execute_i_need_jump, regD_i_allow_in;
    logic        fetch_o_allow_in, imem_o_req_valid, fetch_o_valid, fetch_o_fault;
    logic [63:0] imem_o_req_addr, fetch_o_pc;
    logic [31:0] fetch_o_instr;

    ifetch_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_i_valid          (pc_i_valid),
        .pc_i_pc             (pc_i_pc),
        .fetch_o_allow_in    (fetch_o_allow_in),
        .imem_o_req_valid    (imem_o_req_valid),
        .imem_o_req_addr     (imem_o_req_addr),
        .imem_i_req_ready    (imem_i_req_ready),
        .imem_i_resp_valid   (imem_i_resp_valid),
        .imem_i_resp_data    (imem_i_resp_data),
        .imem_i_resp_err     (imem_i_resp_err),
        .execute_i_need_jump (execute_i_need_jump),
        .regD_i_allow_in     (regD_i_allow_in),
        .fetch_o_valid       (fetch_o_valid),
        .fetch_o_pc          (fetch_o_pc),
        .fetch_o_instr       (fetch_o_instr),
        .fetch_o_fault       (fetch_o_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; bit live; } fl_t;
    typedef struct { logic [63:0] pc; int due; } mem_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; logic fault; } ent_t;

    fl_t  fl[$];   // requests the memory still owes a response for
    mem_t mq[$];   // memory-side pending responses
    ent_t bq[$];   // instructions waiting for decode

    int n_chk = 0, n_err = 0, cyc = 0;
    int lat_min = 1, lat_max = 1;
    logic [63:0] next_pc, redirect_pc, first_pc;
    bit   first_pend = 0, track_lat = 0;
    int   acc_cyc = -1, val_cyc = -1, n_pop = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0013;
    endfunction

    function automatic logic err_of(input logic [63:0] pc);
        return (pc == 64'h8000_0008) || (pc[7:2] == 6'h2B);
    endfunction

    function automatic int dead_count();
        int n = 0;
        foreach (fl[i]) if (!fl[i].live) n++;
        return n;
    endfunction

    function automatic int live_count();
        return fl.size() - dead_count();
    endfunction

    function automatic bit resp_due_next();
        return (mq.size() > 0) && (mq[0].due <= cyc + 1);
    endfunction

    // Compare this cycle's outputs with the model, then advance the model across the next edge.
    task automatic model_step();
        bit    credit, jmp, exp_rv, fire, keep;
        ent_t  e;
        fl_t   f;
        jmp    = execute_i_need_jump;
        credit = (fl.size() + bq.size()) < DEPTH;
        exp_rv = pc_i_valid && credit && !jmp;
        keep   = 0;
        check_eq("req_valid", imem_o_req_valid, exp_rv);
        check_eq("allow_in", fetch_o_allow_in, imem_i_req_ready && credit && !jmp);
        if (exp_rv) check_eq("req_addr", imem_o_req_addr, pc_i_pc);
        e = '{64'h0, 32'h0, 1'b0};
        if (bq.size() > 0) e = bq[0];
        check_eq("fetch_valid", fetch_o_valid, bq.size() > 0);
        check_eq("fetch_pc", fetch_o_pc, e.pc);
        check_eq("fetch_instr", fetch_o_instr, e.instr);
        check_eq("fetch_fault", fetch_o_fault, e.fault);
        check_eq("drop_cnt", dut.drop_cnt, dead_count());
        if (fetch_o_valid && fetch_o_pc == 64'h8000_0008) check_eq("fault_pc8", fetch_o_fault, 1);
        if (first_pend && fetch_o_valid) begin
            check_eq("first_pc", fetch_o_pc, first_pc);
            first_pend = 0;
        end
        if (track_lat && acc_cyc >= 0 && val_cyc < 0 && fetch_o_valid) val_cyc = cyc;
        if (fetch_o_valid && regD_i_allow_in) n_pop++;

        if (imem_i_resp_valid && fl.size() > 0) begin
            f    = fl.pop_front();
            keep = f.live && !jmp;
        end
        if (!jmp && bq.size() > 0 && regD_i_allow_in) void'(bq.pop_front());
        if (keep) bq.push_back('{f.pc, instr_of(f.pc), err_of(f.pc)});
        if (jmp) begin
            bq.delete();
            foreach (fl[i]) fl[i].live = 0;
            next_pc = redirect_pc;
        end
        fire = exp_rv && imem_i_req_ready;
        if (fire) begin
            fl.push_back('{pc_i_pc, 1'b1});
            mq.push_back('{pc_i_pc, cyc + int'($urandom_range(lat_max, lat_min))});
            next_pc = pc_i_pc + 64'd4;
            if (track_lat && acc_cyc < 0) acc_cyc = cyc;
        end
    endtask

    task automatic run_cycle(input logic pcv, input logic mrdy, input logic drdy, input logic jmp);
        mem_t m;
        @(posedge clk);
        #1;
        cyc++;
        pc_i_valid          = pcv;
        pc_i_pc             = next_pc;
        imem_i_req_ready    = mrdy;
        regD_i_allow_in     = drdy;
        execute_i_need_jump = jmp;
        imem_i_resp_valid   = 1'b0;
        imem_i_resp_data    = '0;
        imem_i_resp_err     = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_i_resp_valid = 1'b1;
            imem_i_resp_data  = instr_of(m.pc);
            imem_i_resp_err   = err_of(m.pc);
        end
        @(negedge clk);
        model_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, fetch_o_valid, 0);
        check_eq({tag, "_pc"}, fetch_o_pc, 0);
        check_eq({tag, "_instr"}, fetch_o_instr, 0);
        check_eq({tag, "_fault"}, fetch_o_fault, 0);
        check_eq({tag, "_req_valid"}, imem_o_req_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        pc_i_valid = 1'b1; pc_i_pc = 64'h8000_0000; imem_i_req_ready = 1'b1;
        imem_i_resp_valid = 1'b0; imem_i_resp_data = '0; imem_i_resp_err = 1'b0;
        execute_i_need_jump = 1'b0; regD_i_allow_in = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        pc_i_valid = 1'b0;
        rst = 1'b0;

        // Streaming with a one-cycle memory and decode always ready.
        next_pc = 64'h8000_0000;
        lat_min = 1; lat_max = 1;
        track_lat = 1;
        repeat (4) run_cycle(1, 1, 1, 0);
        track_lat = 0;
        check_eq("first_latency", 64'(val_cyc - acc_cyc), 2);
        n_pop = 0;
        repeat (16) run_cycle(1, 1, 1, 0);
        check_eq("stream_rate", n_pop, 16);

        // Decode stall then drain.
        repeat (5) run_cycle(1, 1, 0, 0);
        repeat (6) run_cycle(1, 1, 1, 0);
        repeat (8) run_cycle(0, 1, 1, 0);

        // Flush with two requests outstanding on a three-cycle memory.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && live_count() < 2; i++) run_cycle(1, 1, 1, 0);
        redirect_pc = 64'h8000_1000;
        run_cycle(1, 1, 1, 1);
        first_pend = 1;
        first_pc   = 64'h8000_1000;
        repeat (12) run_cycle(1, 1, 1, 0);

        // Flushes landing on the same cycle as a response.
        lat_min = 1; lat_max = 3;
        for (int i = 0, done = 0; i < 300; i++) begin
            if (done < 4 && fl.size() >= 2 && resp_due_next()) begin
                redirect_pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
                run_cycle(1, 1, 1, 1);
                done++;
            end else begin
                run_cycle(1, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, 0);
            end
        end

        // Fully random traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            redirect_pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
            run_cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                      $urandom_range(9, 0) < 7, $urandom_range(15, 0) == 0);
        end

        // Asynchronous reset with instructions buffered.
        lat_min = 1; lat_max = 1;
        repeat (4) run_cycle(1, 1, 0, 0);
        @(posedge clk);
        #2;
        pc_i_valid = 1'b1; regD_i_allow_in = 1'b0; execute_i_need_jump = 1'b0;
        imem_i_resp_valid = 1'b0; imem_i_resp_data = '0; imem_i_resp_err = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        fl.delete(); bq.delete(); mq.delete();
        pc_i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        next_pc    = 64'h8000_2000;
        first_pend = 1;
        first_pc   = 64'h8000_2000;
        repeat (10) run_cycle(1, 1, 1, 0);
        if (first_pend) check_eq("post_reset_seen", 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1);
    end
endmodule
